// File: rtl/prewish_blinky_if.sv
// Strobe/data/acknowledge link from the upstream mentor stage into the blinky player.
interface prewish_blinky_if;
   logic       STB_I;
   logic [7:0] DAT_I;
   logic       ACK_O;

   modport master (output STB_I, output DAT_I, input ACK_O);
   modport slave  (input STB_I, input DAT_I, output ACK_O);
endinterface

// File: rtl/prewish_blinky.sv
// Plays an 8-bit blink mask on one LED, MSB first, one bit per prescaled tick, looping.
// Handshake: a mask is accepted on the rising edge of STB_I (STB_I=1 and last cycle's
// STB_I=0); DAT_I is sampled on that edge only and ACK_O is high for the following cycle.
module prewish_blinky #(
   parameter int TICK_DIV = 1500000,
   parameter int CNT_W    = 21
) (
   input  logic               CLK_I,
   input  logic               RST_I,
   prewish_blinky_if.slave    bus,
   output logic               o_led,
   output logic               o_busy,
   output logic               o_alive
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

   state_t           state_q;
   logic [7:0]       mask_q;
   logic [2:0]       bit_idx_q;
   logic [CNT_W-1:0] presc_q;
   logic             stb_q;
   logic             led_q;
   logic             ack_q;
   logic             alive_q;

   logic             accept_d;
   logic [2:0]       bit_idx_d;

   assign accept_d  = bus.STB_I & ~stb_q;
   assign bit_idx_d = bit_idx_q - 3'd1;

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state_q   <= IDLE;
         mask_q    <= 8'h00;
         bit_idx_q <= 3'd7;
         presc_q   <= '0;
         stb_q     <= 1'b0;
         led_q     <= 1'b0;
         ack_q     <= 1'b0;
         alive_q   <= 1'b0;
      end else begin
         stb_q <= bus.STB_I;
         ack_q <= accept_d;
         // An accept always wins over a prescaler wrap on the same edge.
         if (accept_d) begin
            mask_q    <= bus.DAT_I;
            bit_idx_q <= 3'd7;
            presc_q   <= '0;
            led_q     <= bus.DAT_I[7];
            alive_q   <= ~alive_q;
            state_q   <= (bus.DAT_I != 8'h00) ? RUN : IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  presc_q <= '0;
                  led_q   <= 1'b0;
               end
               RUN: begin
                  if (presc_q == PRESC_LAST) begin
                     presc_q   <= '0;
                     bit_idx_q <= bit_idx_d;
                     led_q     <= mask_q[bit_idx_d];
                  end else begin
                     presc_q <= presc_q + 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.ACK_O = ack_q;
   assign o_led     = led_q;
   assign o_busy    = (state_q == RUN);
   assign o_alive   = alive_q;

endmodule

// File: tb/tb_prewish_blinky.sv
// Bench for prewish_blinky: per-cycle expected {ack,busy,alive,led} pushed at stimulus time.
module tb_prewish_blinky;

   localparam int TICK = 4;

   logic clk;
   logic rst_n;
   logic led, busy, alive;

   prewish_blinky_if bus ();

   prewish_blinky #(.TICK_DIV(TICK), .CNT_W(3)) dut (
      .CLK_I   (clk),
      .RST_I   (rst_n),
      .bus     (bus),
      .o_led   (led),
      .o_busy  (busy),
      .o_alive (alive)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] exp_q[$];
   int         n_chk = 0;
   int         n_bad = 0;
   logic       exp_alive = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected outputs for n cycles following an accept of mask m (first entry = accepting edge).
   task automatic push_pattern(input logic [7:0] m, input int n);
      logic [2:0] idx;
      for (int i = 0; i < n; i++) begin
         idx = 3'(7 - ((i / TICK) % 8));
         exp_q.push_back({(i == 0), (m != 8'h00), exp_alive, (m != 8'h00) ? m[idx] : 1'b0});
      end
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 1'b0, exp_alive, 1'b0});
   endtask

   // driver: apply inputs, clock once, compare against the head of the queue
   task automatic step(input logic stb, input logic [7:0] dat, input string tag);
      logic [3:0] e;
      bus.STB_I = stb;
      bus.DAT_I = dat;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, "_underflow"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk(tag, {28'd0, bus.ACK_O, busy, alive, led}, {28'd0, e});
      end
   endtask

   task automatic idle_steps(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 8'($urandom_range(0, 255)), tag);
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.STB_I = 1'b0;
      bus.DAT_I = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", {28'd0, bus.ACK_O, busy, alive, led}, 32'd0);
      rst_n = 1'b1;
      push_idle(20);
      idle_steps(20, "idle");

      // play out A5, including the wrap back to bit 7 after 32 cycles
      exp_alive = ~exp_alive;
      push_pattern(8'hA5, 33);
      step(1'b1, 8'hA5, "play_a5");
      idle_steps(32, "play_a5");

      // reload mid-pattern with 0F at k+10
      exp_alive = ~exp_alive;
      push_pattern(8'hA5, 10);
      step(1'b1, 8'hA5, "pre_reload");
      idle_steps(9, "pre_reload");
      exp_alive = ~exp_alive;
      push_pattern(8'h0F, 33);
      step(1'b1, 8'h0F, "reload_0f");
      idle_steps(32, "reload_0f");

      // zero mask while running drops to IDLE at the accepting edge
      exp_alive = ~exp_alive;
      push_pattern(8'h00, 10);
      step(1'b1, 8'h00, "zero_mask");
      idle_steps(9, "zero_mask");

      // held strobe: only the rising edge counts, later DAT_I ignored
      exp_alive = ~exp_alive;
      push_pattern(8'h81, 36);
      step(1'b1, 8'h81, "held_stb");
      for (int i = 0; i < 4; i++) step(1'b1, 8'hFF, "held_stb");
      idle_steps(31, "held_stb");

      // async reset mid-RUN inside a slot of FF
      exp_alive = ~exp_alive;
      push_pattern(8'hFF, 6);
      step(1'b1, 8'hFF, "pre_arst");
      idle_steps(5, "pre_arst");
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_led", {31'd0, led}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_ack", {31'd0, bus.ACK_O}, 32'd0);
      chk("arst_alive", {31'd0, alive}, 32'd0);
      exp_alive = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_idle(15);
      idle_steps(15, "post_arst");

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/prewish_blinky.md
Name: prewish_blinky

Overview:
- Downstream consumer of the mentor stage's STB_O/DAT_O byte output. Accepts an 8-bit blink mask over a strobe/data interface and plays it out on a single LED, MSB first, one bit per prescaled tick, looping.
- A new strobe restarts playback with the new mask.
- Returns a one-cycle acknowledge per accepted mask and a debug alive toggle.

Parameters:
- TICK_DIV, 1500000, clock cycles each mask bit is held on o_led (legal range >= 2; 125 ms at 12 MHz).
- CNT_W, 21, prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- CLK_I  in  1  system clock, all state on rising edge.
- RST_I  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- STB_I  in  1  mask strobe from the upstream mentor; rising edge qualifies.
- DAT_I  in  8  blink mask; sampled on the accepting edge.
- ACK_O  out 1  one-cycle pulse, the cycle after a mask is accepted.
- o_led  out 1  registered LED drive.
- o_busy out 1  1 while in RUN.
- o_alive out 1 debug; toggles on every accepted mask.

Behaviour:
- Reset (RST_I=0, async):
  - State=IDLE, mask=8'h00, bit_idx=7, presc=0, stb_d=0.
  - o_led=0, ACK_O=0, o_busy=0, o_alive=0.
  - Release is synchronous to the next CLK_I edge.
- Accept condition: STB_I=1 and stb_d=0, where stb_d is STB_I registered each cycle.
  - STB_I held high for N cycles yields exactly one accept.
  - A new accept needs STB_I to return low for at least 1 cycle.
- On an accept at edge k:
  - mask<=DAT_I, bit_idx<=7, presc<=0, o_led<=DAT_I[7], o_alive toggles.
  - State<=RUN if DAT_I!=0, else IDLE.
  - ACK_O=1 for exactly the cycle after edge k, regardless of DAT_I value.
- IDLE: o_led=0, presc held at 0, o_busy=0. Leaves only on an accept with nonzero mask.
- RUN:
  - presc counts 0..TICK_DIV-1 and increments each cycle.
  - At presc==TICK_DIV-1: presc<=0, bit_idx<=bit_idx-1 (0 wraps to 7), o_led<=mask[new bit_idx].
  - Each mask bit is therefore visible on o_led for exactly TICK_DIV cycles; the full pattern period is 8*TICK_DIV cycles.
  - RUN is endless; no completion event.
- Accept during RUN (any presc/bit_idx): the new mask takes effect at the accepting edge with identical behaviour to an accept from IDLE. Partial bit time is discarded; no merge with the old mask.
- Accept with DAT_I=8'h00 during RUN: goes to IDLE at that edge, o_led=0, ACK_O still pulses.
- Accept coinciding with the prescaler wrap edge: the accept wins; the tick is discarded.
- Reset asserted mid-RUN: o_led drops to 0 asynchronously, without waiting for a clock; the mask is lost.
- DAT_I is ignored on every cycle that is not an accept.
- No arithmetic overflow is permitted: presc never exceeds TICK_DIV-1.

Test Plan (TICK_DIV=4, CNT_W=3):
- Reset: hold RST_I=0 for 3 cycles, then release.
  - o_led=0, ACK_O=0, o_busy=0, o_alive=0.
  - Outputs stay there for 20 cycles with STB_I=0.
- Play out: 1-cycle STB_I with DAT_I=8'hA5 accepted at edge k.
  - ACK_O=1 only in cycle k+1; o_busy=1; o_alive=1.
  - o_led per 4-cycle slot from k: 1,0,1,0,0,1,0,1.
  - At k+32, o_led returns to 1 (wrap).
- Reload mid-pattern: with 8'hA5 running, strobe 8'h0F at k+10.
  - o_led=0 for k+10..k+25, then 1 for k+26..k+41.
  - Exactly one ACK_O pulse at k+11.
- Zero mask: strobe 8'h00 while running.
  - IDLE entered and o_busy=0 at the accepting edge; o_led=0 from then on.
  - ACK_O pulses once; o_alive toggles.
- Held strobe: STB_I=1 for 5 cycles with DAT_I changing 8'h81→8'hFF mid-hold.
  - Single accept of 8'h81; one ACK_O pulse; o_alive toggles once.
  - Pattern 1,0,0,0,0,0,0,1.
- Async reset mid-RUN: drive RST_I low between clock edges during a 1-bit slot of 8'hFF.
  - o_led=0, o_busy=0, ACK_O=0 before the next rising edge.
  - After release, the block stays IDLE until a new strobe.
